branch_rs_array: RTL
====================

BRANCH_RS_ARRAY -- requirements
Module: branch_rs_array

Interface
REQ-001 SHALL have parameters: FUINDEX, default 0, FU number this station answers to; RS_DEPTH, default 4, entry count (2..16); WORD_SIZE, default 32, operand width; RB_INDEX, default 4, reorder-buffer tag width; RB_SIZE, default 16, CDB slot count.
REQ-002 SHALL have ports (name  direction  width  meaning):
clk  in  1  single clock; all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
issue_valid  in  1  issue slot carries an instruction.
issue_fu  in  FU_INDEX  target FU; accepted only when equal to FUINDEX.
issue_rb_index  in  RB_INDEX  destination reorder-buffer tag.
issue_op  in  2  compare mode: 00 GE, 01 LT, 10 EQ, 11 NE.
issue_vj, issue_vk  in  WORD_SIZE  operand values from RB/register file.
issue_qj, issue_qk  in  RB_INDEX  producer tags; READY means value valid.
issue_imm_sel  in  1  operand k comes from issue_imm; issue_qk ignored.
issue_imm  in  WORD_SIZE  sign-extended immediate.
flush  in  1  synchronous kill of all entries and pending result.
cdb_data  in  WORD_SIZE*RB_SIZE  CDB data, slot i at bits [i*WORD_SIZE +: WORD_SIZE].
cdb_valid  in  RB_SIZE  CDB slot valid.
busy_out  out  1  station full; no issue accepted.
result_valid  out  1  result register holds a result.
result_ready  in  1  consumer accepts the result this edge.
result_data  out  WORD_SIZE  compare outcome, zero-extended 0/1.
result_rb_index  out  RB_INDEX  tag of result; NULL when result_valid low.

Function
REQ-003 SHALL accept an issue on an edge where issue_valid=1, issue_fu=FUINDEX, busy_out=0 and flush=0, allocating the lowest-index free entry.
REQ-004 SHALL capture each operand at issue: q=READY -> value; else cdb_valid[q]=1 that cycle -> cdb_data slot q, tag READY; else store tag.
REQ-005 SHALL, every edge, replace each stored non-READY tag whose cdb_valid bit is 1 with that slot's data and set tag READY.
REQ-006 SHALL treat an entry as ready only when both stored tags are READY at the start of the cycle (no same-edge CDB-to-select bypass).
REQ-007 SHALL keep an age rank per entry: allocate with rank = current occupancy; on free, decrement ranks greater than the freed rank.
REQ-008 SHALL select the ready entry with lowest rank when result_valid=0 or result_ready=1, load result register at that edge, free the entry in the same edge.
REQ-009 SHALL hold result_valid, result_data and result_rb_index stable until accepted by result_ready=1.
REQ-010 SHALL give minimum latency of two edges from issue (both operands READY) to result_valid high; one result per cycle sustained.
REQ-011 SHALL drive busy_out from registered occupancy = RS_DEPTH; a free on the same edge does not admit an issue.
REQ-012 SHALL, on flush, clear all entries, ranks and result_valid at that edge; flush wins over issue and selection.

Reset
REQ-013 SHALL, when reset_n=0, immediately clear all entries, busy_out=0, result_valid=0, result_data=0, result_rb_index=NULL.

Configuration
REQ-014 SHALL, with BRANCH_RS_SIGNED_CMP_EN defined, evaluate GE/LT as two's-complement signed; without it, GE/LT unsigned; EQ/NE unaffected.

Structure
REQ-015 SHALL take READY, NULL, FU_INDEX and the 2-bit compare-op encoding from the shared parameters package; no local redefinition.
REQ-016 SHALL place the compare in sub-module branch_cmp (op, a, b -> 1-bit), combinational, instantiated once after the selection mux.

Verification
REQ-017 Issue GE vj=5 vk imm 3, both READY, result_ready=1 -> result_valid after 2nd edge, data=1, tag=issue tag.
REQ-018 Issue EQ qj=7 waiting; 3 cycles later cdb_valid[7]=1 data=9, vk=9 -> result data=1 two edges after CDB cycle.
REQ-019 Fill RS_DEPTH entries all waiting -> busy_out=1, further issue ignored; release in reverse order -> results emitted oldest ready first.
REQ-020 result_ready=0 for 5 cycles with two ready entries -> first result held stable, second emitted the edge after acceptance.
REQ-021 LT vj=0xFFFFFFFF vk=1 -> data=1 with BRANCH_RS_SIGNED_CMP_EN, 0 without.
REQ-022 Assert flush, then reset_n mid-operation with 3 entries busy -> all entries empty, result_valid=0, result_rb_index=NULL immediately.

Source files
------------

// File: rtl/branch_rs_array_pkg.sv
// Shared constants for the branch reservation station: tag sentinels, FU id width
// and the 2-bit compare-op encoding used by issue logic and the comparator.
package branch_rs_array_pkg;

    localparam int FU_INDEX = 2;
    // Tag value 0 is reserved: in an operand it means "value present", on the
    // result port it means "no result".
    localparam int READY = 0;
    localparam int NULL  = 0;

    typedef enum logic [1:0] {
        CMP_GE = 2'b00,
        CMP_LT = 2'b01,
        CMP_EQ = 2'b10,
        CMP_NE = 2'b11
    } cmp_op_e;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: single-bit outcome of a GE/LT/EQ/NE compare.
// GE/LT are signed when BRANCH_RS_SIGNED_CMP_EN is defined, unsigned otherwise.
module branch_cmp
    import branch_rs_array_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  cmp_op_e              op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 taken
);

    logic lt;

    always_comb begin
`ifdef BRANCH_RS_SIGNED_CMP_EN
        lt = $signed(a) < $signed(b);
`else
        lt = a < b;
`endif
        case (op)
            CMP_GE:  taken = ~lt;
            CMP_LT:  taken = lt;
            CMP_EQ:  taken = (a == b);
            CMP_NE:  taken = (a != b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_rs_array.sv
// Branch reservation station: holds compare ops until both operands arrive from
// the CDB, issues oldest-ready to one registered result. Option: BRANCH_RS_SIGNED_CMP_EN.
module branch_rs_array
    import branch_rs_array_pkg::*;
#(
    parameter int FUINDEX   = 0,
    parameter int RS_DEPTH  = 4,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    parameter int RB_SIZE   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          issue_valid,
    input  logic [FU_INDEX-1:0]           issue_fu,
    input  logic [RB_INDEX-1:0]           issue_rb_index,
    input  logic [1:0]                    issue_op,
    input  logic [WORD_SIZE-1:0]          issue_vj,
    input  logic [WORD_SIZE-1:0]          issue_vk,
    input  logic [RB_INDEX-1:0]           issue_qj,
    input  logic [RB_INDEX-1:0]           issue_qk,
    input  logic                          issue_imm_sel,
    input  logic [WORD_SIZE-1:0]          issue_imm,
    input  logic                          flush,
    input  logic [WORD_SIZE*RB_SIZE-1:0]  cdb_data,
    input  logic [RB_SIZE-1:0]            cdb_valid,
    output logic                          busy_out,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [WORD_SIZE-1:0]          result_data,
    output logic [RB_INDEX-1:0]           result_rb_index
);

    localparam int RANK_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RS_DEPTH + 1);
    localparam logic [RB_INDEX-1:0] TAG_READY = RB_INDEX'(READY);
    localparam logic [RB_INDEX-1:0] TAG_NULL  = RB_INDEX'(NULL);

    // Entry storage
    logic [RS_DEPTH-1:0]  ent_valid;
    logic [RANK_W-1:0]    ent_rank [RS_DEPTH];
    cmp_op_e              ent_op   [RS_DEPTH];
    logic [RB_INDEX-1:0]  ent_rb   [RS_DEPTH];
    logic [RB_INDEX-1:0]  ent_qj   [RS_DEPTH];
    logic [RB_INDEX-1:0]  ent_qk   [RS_DEPTH];
    logic [WORD_SIZE-1:0] ent_vj   [RS_DEPTH];
    logic [WORD_SIZE-1:0] ent_vk   [RS_DEPTH];
    logic [CNT_W-1:0]     count;

    // Returns {hit, data} for a tag against the current CDB broadcast.
    function automatic logic [WORD_SIZE:0] cdb_lookup(
        input logic [RB_INDEX-1:0]          tag,
        input logic [RB_SIZE-1:0]           valid,
        input logic [WORD_SIZE*RB_SIZE-1:0] data
    );
        logic [WORD_SIZE:0] hit;
        hit = '0;
        for (int s = 0; s < RB_SIZE; s++) begin
            if (tag == RB_INDEX'(s) && valid[s])
                hit = {1'b1, data[s*WORD_SIZE +: WORD_SIZE]};
        end
        return hit;
    endfunction

    // Wakeup and readiness
    logic [RS_DEPTH-1:0]  wake_j, wake_k, ent_ready;
    logic [WORD_SIZE-1:0] wake_j_data [RS_DEPTH];
    logic [WORD_SIZE-1:0] wake_k_data [RS_DEPTH];

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            {wake_j[i], wake_j_data[i]} = cdb_lookup(ent_qj[i], cdb_valid, cdb_data);
            {wake_k[i], wake_k_data[i]} = cdb_lookup(ent_qk[i], cdb_valid, cdb_data);
            wake_j[i] = wake_j[i] && ent_valid[i] && (ent_qj[i] != TAG_READY);
            wake_k[i] = wake_k[i] && ent_valid[i] && (ent_qk[i] != TAG_READY);
            // Registered tags only: a CDB hit this cycle becomes selectable next cycle.
            ent_ready[i] = ent_valid[i] && (ent_qj[i] == TAG_READY) && (ent_qk[i] == TAG_READY);
        end
    end

    // Oldest-ready selection and lowest-free allocation
    logic              sel_found;
    logic [RANK_W-1:0] sel_idx;
    logic [RANK_W-1:0] sel_rank;
    logic              alloc_found;
    logic [RANK_W-1:0] alloc_idx;

    always_comb begin
        sel_found   = 1'b0;
        sel_idx     = '0;
        sel_rank    = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_ready[i] && (!sel_found || ent_rank[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = RANK_W'(i);
                sel_rank  = ent_rank[i];
            end
            if (!ent_valid[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = RANK_W'(i);
            end
        end
    end

    // Result handshake: result_valid/data/rb_index are held while result_valid=1
    // and result_ready=0; the register reloads or empties on any edge where it is
    // empty or the consumer takes it (result_valid=1 and result_ready=1).
    logic              take;
    logic              do_sel;
    logic              do_issue;
    logic [RANK_W-1:0] alloc_rank;

    assign busy_out   = (count == CNT_W'(RS_DEPTH));
    assign take       = !result_valid || result_ready;
    assign do_sel     = take && sel_found && !flush;
    assign do_issue   = issue_valid && (issue_fu == FU_INDEX'(FUINDEX)) && !busy_out && !flush;
    // New entry is youngest among the survivors of this edge.
    assign alloc_rank = RANK_W'(count - CNT_W'(do_sel));

    // Operand capture at issue, including a same-cycle CDB hit
    logic [WORD_SIZE:0]   iss_j_cdb, iss_k_cdb;
    logic [WORD_SIZE-1:0] iss_vj, iss_vk;
    logic [RB_INDEX-1:0]  iss_qj, iss_qk;

    always_comb begin
        iss_j_cdb = cdb_lookup(issue_qj, cdb_valid, cdb_data);
        iss_k_cdb = cdb_lookup(issue_qk, cdb_valid, cdb_data);
        iss_vj    = issue_vj;
        iss_qj    = issue_qj;
        iss_vk    = issue_vk;
        iss_qk    = issue_qk;
        if (issue_qj == TAG_READY) begin
            iss_qj = TAG_READY;
        end else if (iss_j_cdb[WORD_SIZE]) begin
            iss_vj = iss_j_cdb[WORD_SIZE-1:0];
            iss_qj = TAG_READY;
        end
        if (issue_imm_sel) begin
            iss_vk = issue_imm;
            iss_qk = TAG_READY;
        end else if (issue_qk == TAG_READY) begin
            iss_qk = TAG_READY;
        end else if (iss_k_cdb[WORD_SIZE]) begin
            iss_vk = iss_k_cdb[WORD_SIZE-1:0];
            iss_qk = TAG_READY;
        end
    end

    // Selection mux feeding the single comparator
    cmp_op_e              sel_op;
    logic [WORD_SIZE-1:0] sel_vj, sel_vk;
    logic [RB_INDEX-1:0]  sel_rb;
    logic                 cmp_taken;

    assign sel_op = ent_op[sel_idx];
    assign sel_vj = ent_vj[sel_idx];
    assign sel_vk = ent_vk[sel_idx];
    assign sel_rb = ent_rb[sel_idx];

    branch_cmp #(.WORD_SIZE(WORD_SIZE)) u_cmp (
        .op    (sel_op),
        .a     (sel_vj),
        .b     (sel_vk),
        .taken (cmp_taken)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid       <= '0;
            count           <= '0;
            result_valid    <= 1'b0;
            result_data     <= '0;
            result_rb_index <= TAG_NULL;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_rank[i] <= '0;
                ent_op[i]   <= CMP_GE;
                ent_rb[i]   <= '0;
                ent_qj[i]   <= '0;
                ent_qk[i]   <= '0;
                ent_vj[i]   <= '0;
                ent_vk[i]   <= '0;
            end
        end else if (flush) begin
            ent_valid       <= '0;
            count           <= '0;
            result_valid    <= 1'b0;
            result_data     <= '0;
            result_rb_index <= TAG_NULL;
            for (int i = 0; i < RS_DEPTH; i++)
                ent_rank[i] <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent_valid[i]) begin
                    if (wake_j[i]) begin
                        ent_vj[i] <= wake_j_data[i];
                        ent_qj[i] <= TAG_READY;
                    end
                    if (wake_k[i]) begin
                        ent_vk[i] <= wake_k_data[i];
                        ent_qk[i] <= TAG_READY;
                    end
                    if (do_sel && sel_idx == RANK_W'(i))
                        ent_valid[i] <= 1'b0;
                    else if (do_sel && ent_rank[i] > sel_rank)
                        ent_rank[i] <= ent_rank[i] - 1'b1;
                end
            end
            if (do_issue) begin
                ent_valid[alloc_idx] <= 1'b1;
                ent_rank[alloc_idx]  <= alloc_rank;
                ent_op[alloc_idx]    <= cmp_op_e'(issue_op);
                ent_rb[alloc_idx]    <= issue_rb_index;
                ent_vj[alloc_idx]    <= iss_vj;
                ent_qj[alloc_idx]    <= iss_qj;
                ent_vk[alloc_idx]    <= iss_vk;
                ent_qk[alloc_idx]    <= iss_qk;
            end
            count <= count + CNT_W'(do_issue) - CNT_W'(do_sel);
            if (take) begin
                if (do_sel) begin
                    result_valid    <= 1'b1;
                    result_data     <= {{(WORD_SIZE-1){1'b0}}, cmp_taken};
                    result_rb_index <= sel_rb;
                end else begin
                    result_valid    <= 1'b0;
                    result_data     <= '0;
                    result_rb_index <= TAG_NULL;
                end
            end
        end
    end

endmodule
